dq_rdwr_scheduler: RTL

Read/write CAS scheduler for one channel's DQ bus. Sits between the per-channel read and write CAS queues and the command issue path. Grants at most one CAS per cycle and enforces all DQ-bus CAS spacing:
- tCCD_S/tCCD_L between same-direction CASes.
- tRTW on read→write turnaround.
- tWTR_S/tWTR_L on write→read turnaround.

A burst limit prevents either direction from starving the other.

---
 rtl/dq_sched_pkg.sv | 26 ++
 rtl/dq_gap_counter.sv | 31 +++
 rtl/dq_rdwr_scheduler.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dq_sched_pkg.sv
// Shared types and helpers for the DQ-bus read/write CAS scheduler.
package dq_sched_pkg;

   typedef enum logic [1:0] {
      DQ_RD    = 2'd0,
      DQ_RD2WR = 2'd1,
      DQ_WR    = 2'd2,
      DQ_WR2RD = 2'd3
   } dq_state_t;

   localparam logic DIR_RD = 1'b0;
   localparam logic DIR_WR = 1'b1;

   // Largest of the CAS spacing parameters; sizes the elapsed counter.
   function automatic int dq_max_timing(input int a, input int b, input int c,
                                        input int d, input int e);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      if (e > m) m = e;
      return m;
   endfunction

endpackage

// File: rtl/dq_gap_counter.sv
// Saturating count of cycles since the last granted CAS; reloads to 1 the
// cycle after a grant.
module dq_gap_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         grant,
   output logic [W-1:0] elapsed
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] elapsed_r;

   // Elapsed-cycle register, saturating at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         elapsed_r <= {W{1'b1}};
      end else if (grant) begin
         elapsed_r <= ONE;
      end else if (elapsed_r != {W{1'b1}}) begin
         elapsed_r <= elapsed_r + ONE;
      end else begin
         elapsed_r <= elapsed_r;
      end
   end

   assign elapsed = elapsed_r;

endmodule

// File: rtl/dq_rdwr_scheduler.sv
// Read/write CAS scheduler for one channel's DQ bus: one grant per cycle,
// tCCD/tRTW/tWTR spacing and a per-direction burst limit.
module dq_rdwr_scheduler
   import dq_sched_pkg::*;
#(
   parameter int BG_WIDTH  = 2,
   parameter int tCCDS     = 4,
   parameter int tCCDL     = 6,
   parameter int tRTW      = 8,
   parameter int tWTRS     = 12,
   parameter int tWTRL     = 16,
   parameter int MAX_BURST = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdReq,
   input  logic [BG_WIDTH-1:0] rdBG,
   input  logic                wrReq,
   input  logic [BG_WIDTH-1:0] wrBG,
   input  logic                casHold,
   output logic                rdGnt,
   output logic                wrGnt,
   output logic                dqDir
);

   localparam int EW = $clog2(dq_max_timing(tCCDS, tCCDL, tRTW, tWTRS, tWTRL) + 1);
   localparam int BW = $clog2(MAX_BURST + 1);

   localparam logic [EW-1:0] G_CCDS = EW'(tCCDS);
   localparam logic [EW-1:0] G_CCDL = EW'(tCCDL);
   localparam logic [EW-1:0] G_RTW  = EW'(tRTW);
   localparam logic [EW-1:0] G_WTRS = EW'(tWTRS);
   localparam logic [EW-1:0] G_WTRL = EW'(tWTRL);
   localparam logic [BW-1:0] BURST_ONE = {{(BW-1){1'b0}}, 1'b1};
   localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

   dq_state_t           state_r, state_nxt_s;
   logic [EW-1:0]       elapsed_s;
   logic [BW-1:0]       burst_cnt_r;
   logic [BG_WIDTH-1:0] last_bg_r;
   logic                last_was_wr_r;
   logic [EW-1:0]       rd_gap_s, wr_gap_s;
   logic                rd_legal_s, wr_legal_s, burst_max_s;
   logic                rd_gnt_s, wr_gnt_s, any_gnt_s;

   dq_gap_counter #(.W(EW)) u_gap (
      .clk     (clk),
      .rst     (rst),
      .grant   (any_gnt_s),
      .elapsed (elapsed_s)
   );

   // Required gap for each candidate, given the direction and bank group of the last CAS.
   always_comb begin
      rd_gap_s = G_CCDS;
      wr_gap_s = G_RTW;
      if (last_was_wr_r == DIR_WR) begin
         rd_gap_s = (rdBG == last_bg_r) ? G_WTRL : G_WTRS;
         wr_gap_s = (wrBG == last_bg_r) ? G_CCDL : G_CCDS;
      end else begin
         rd_gap_s = (rdBG == last_bg_r) ? G_CCDL : G_CCDS;
         wr_gap_s = G_RTW;
      end
   end

   assign rd_legal_s  = rdReq && !casHold && (elapsed_s >= rd_gap_s);
   assign wr_legal_s  = wrReq && !casHold && (elapsed_s >= wr_gap_s);
   assign burst_max_s = (burst_cnt_r == BURST_MAX);

   // Next-state and grant decode; a direction at its burst limit yields while the other waits.
   always_comb begin
      state_nxt_s = state_r;
      rd_gnt_s    = 1'b0;
      wr_gnt_s    = 1'b0;
      case (state_r)
         DQ_RD: begin
            rd_gnt_s = rd_legal_s && !(wrReq && burst_max_s);
            if (wrReq && (!rdReq || burst_max_s)) state_nxt_s = DQ_RD2WR;
            else                                  state_nxt_s = DQ_RD;
         end
         DQ_RD2WR: begin
            if (wr_legal_s) begin
               wr_gnt_s    = 1'b1;
               state_nxt_s = DQ_WR;
            end else if (!wrReq && rdReq) begin
               state_nxt_s = DQ_RD;
            end else begin
               state_nxt_s = DQ_RD2WR;
            end
         end
         DQ_WR: begin
            wr_gnt_s = wr_legal_s && !(rdReq && burst_max_s);
            if (rdReq && (!wrReq || burst_max_s)) state_nxt_s = DQ_WR2RD;
            else                                  state_nxt_s = DQ_WR;
         end
         DQ_WR2RD: begin
            if (rd_legal_s) begin
               rd_gnt_s    = 1'b1;
               state_nxt_s = DQ_RD;
            end else if (!rdReq && wrReq) begin
               state_nxt_s = DQ_WR;
            end else begin
               state_nxt_s = DQ_WR2RD;
            end
         end
         default: begin
            state_nxt_s = DQ_RD;
         end
      endcase
   end

   assign any_gnt_s = rd_gnt_s || wr_gnt_s;

   // State, burst count and last-CAS bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= DQ_RD;
         burst_cnt_r   <= {BW{1'b0}};
         last_bg_r     <= {BG_WIDTH{1'b0}};
         last_was_wr_r <= DIR_RD;
      end else begin
         state_r <= state_nxt_s;
         if (any_gnt_s) begin
            last_bg_r     <= rd_gnt_s ? rdBG : wrBG;
            last_was_wr_r <= wr_gnt_s ? DIR_WR : DIR_RD;
            if (state_r == DQ_RD2WR || state_r == DQ_WR2RD) begin
               burst_cnt_r <= BURST_ONE;
            end else if (!burst_max_s) begin
               burst_cnt_r <= burst_cnt_r + BURST_ONE;
            end else begin
               burst_cnt_r <= burst_cnt_r;
            end
         end else begin
            last_bg_r     <= last_bg_r;
            last_was_wr_r <= last_was_wr_r;
            burst_cnt_r   <= burst_cnt_r;
         end
      end
   end

   assign rdGnt = rd_gnt_s;
   assign wrGnt = wr_gnt_s;
   assign dqDir = (state_r == DQ_WR || state_r == DQ_RD2WR) ? DIR_WR : DIR_RD;

endmodule
